// File: rtl/turbo_pkg.sv
// Shared turbo-decoder bus constants, header layout and feeder FSM states.
package turbo_pkg;

  localparam int BUS                   = 534;
  localparam int NUM_BUS_PER_TURBO_PKT = 25;
  localparam int NUM_TURBO             = 16;
  localparam int PAYLOAD_W             = 512;

  localparam int HDR_LAST_OFF = 0;
  localparam int HDR_LAST_W   = 1;
  localparam int HDR_IDX_OFF  = 1;
  localparam int HDR_IDX_W    = 5;
  localparam int HDR_SEQ_OFF  = 6;
  localparam int HDR_SEQ_W    = 16;
  localparam int HDR_W        = HDR_SEQ_W + HDR_IDX_W + HDR_LAST_W;

  typedef struct packed {
    logic [HDR_SEQ_W-1:0] pkt_seq;
    logic [HDR_IDX_W-1:0] word_idx;
    logic                 last;
  } hdr_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } feed_state_t;

  function automatic logic [HDR_W-1:0] make_hdr(input logic [HDR_SEQ_W-1:0] seq,
                                                input logic [HDR_IDX_W-1:0] idx,
                                                input logic                 last);
    logic [HDR_W-1:0] h;
    h = '0;
    h[HDR_SEQ_OFF +: HDR_SEQ_W]   = seq;
    h[HDR_IDX_OFF +: HDR_IDX_W]   = idx;
    h[HDR_LAST_OFF +: HDR_LAST_W] = last;
    return h;
  endfunction

endpackage

// File: rtl/trb_feed_fifo.sv
// Synchronous FIFO with registered count; read data is the combinational head entry.
// A push while full is accepted only when a pop happens in the same cycle.
module trb_feed_fifo #(
  parameter int W     = 512,
  parameter int DEPTH = 32
) (
  input  logic                   clk_bus,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [W-1:0]           wdata,
  input  logic                   pop,
  output logic [W-1:0]           rdata,
  output logic                   push_ok,
  output logic [$clog2(DEPTH):0] count,
  output logic [$clog2(DEPTH):0] count_nxt,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && (!full || pop);
  assign rdata   = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({push_ok, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk_bus) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk_bus) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)     rd_ptr <= ptr_inc(rd_ptr);
      count <= count_nxt;
    end
  end

endmodule

// File: rtl/trb_bus_feeder.sv
// Buffers payload words and issues whole turbo packets as {hdr, payload} on bus_data.
// bus_data/bus_en lag the FIFO head by one cycle; stalls on bus_ready=0, throttles upstream via in_ready.
module trb_bus_feeder #(
  parameter int BUS                   = turbo_pkg::BUS,
  parameter int NUM_BUS_PER_TURBO_PKT = turbo_pkg::NUM_BUS_PER_TURBO_PKT,
  parameter int FIFO_DEPTH            = 32,
  parameter int IN_SLACK              = 4
) (
  input  logic                            clk_bus,
  input  logic                            rst_n,
  input  logic                            in_valid,
  input  logic [turbo_pkg::PAYLOAD_W-1:0] in_data,
  output logic                            in_ready,
  output logic [BUS-1:0]                  bus_data,
  output logic                            bus_en,
  input  logic                            bus_ready,
  output logic [15:0]                     pkt_cnt,
  output logic                            ovf_err
);

  import turbo_pkg::*;

  localparam int                CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]     PKT_WORDS = CW'(NUM_BUS_PER_TURBO_PKT);
  localparam logic [CW-1:0]     RDY_LIMIT = CW'(FIFO_DEPTH - IN_SLACK);
  localparam logic [HDR_IDX_W-1:0] LAST_IDX = HDR_IDX_W'(NUM_BUS_PER_TURBO_PKT - 1);

  feed_state_t            state_q, state_d;
  logic                   gap_q, gap_d;
  logic [HDR_IDX_W-1:0]   word_idx;
  logic [HDR_SEQ_W-1:0]   pkt_seq;
  logic                   last;
  hdr_t                   hdr;
  logic                   pop;
  logic                   push_ok;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [CW-1:0]          occ;
  logic [CW-1:0]          occ_nxt;
  logic [PAYLOAD_W-1:0]   head;

  // Sequence number and completed-packet count advance together, so share one register.
  assign pkt_seq = pkt_cnt;
  assign last    = (word_idx == LAST_IDX);
  assign hdr     = make_hdr(pkt_seq, word_idx, last);

  trb_feed_fifo #(
    .W     (PAYLOAD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_bus   (clk_bus),
    .rst_n     (rst_n),
    .push      (in_valid),
    .wdata     (in_data),
    .pop       (pop),
    .rdata     (head),
    .push_ok   (push_ok),
    .count     (occ),
    .count_nxt (occ_nxt),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (occ >= PKT_WORDS) state_d = ST_SEND;
      end
      ST_SEND: begin
        if (bus_ready && !fifo_empty) begin
          pop = 1'b1;
          if (last) begin
            state_d = ST_GAP;
            gap_d   = 1'b0;
          end
        end
      end
      ST_GAP: begin
        // Two-cycle hold; a fully buffered next packet restarts without an extra idle cycle.
        if (!gap_q) begin
          gap_d = 1'b1;
        end else begin
          gap_d   = 1'b0;
          state_d = (occ >= PKT_WORDS) ? ST_SEND : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_bus) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      gap_q    <= 1'b0;
      word_idx <= '0;
      pkt_cnt  <= '0;
      bus_en   <= 1'b0;
      bus_data <= '0;
      in_ready <= 1'b0;
      ovf_err  <= 1'b0;
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      bus_en   <= pop;
      in_ready <= (occ_nxt <= RDY_LIMIT);
      if (in_valid && !push_ok) ovf_err <= 1'b1;
      if (pop) begin
        bus_data <= BUS'({hdr, head});
        word_idx <= last ? '0 : word_idx + HDR_IDX_W'(1);
        if (last) pkt_cnt <= pkt_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_trb_bus_feeder.sv
// Directed bench for trb_bus_feeder: packet framing, gaps, stalls, overflow and mid-packet reset.
module tb_trb_bus_feeder;

  logic         clk_bus   = 1'b0;
  logic         rst_n     = 1'b0;
  logic         in_valid  = 1'b0;
  logic [511:0] in_data   = '0;
  logic         bus_ready = 1'b0;
  logic         in_ready;
  logic [533:0] bus_data;
  logic         bus_en;
  logic [15:0]  pkt_cnt;
  logic         ovf_err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int hold_bad = 0;

  logic [533:0] cap_q[$];
  int           cap_cyc[$];
  bit           cap_rdy[$];
  logic [533:0] prev_data = '0;

  always #5 clk_bus = ~clk_bus;

  trb_bus_feeder dut (
    .clk_bus   (clk_bus),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .bus_data  (bus_data),
    .bus_en    (bus_en),
    .bus_ready (bus_ready),
    .pkt_cnt   (pkt_cnt),
    .ovf_err   (ovf_err)
  );

  always @(posedge clk_bus) cyc++;

  // Capture every issued word together with the bus_ready seen at its edge.
  always @(posedge clk_bus) begin : mon
    logic rdy_e;
    logic rst_e;
    rdy_e = bus_ready;
    rst_e = rst_n;
    #1;
    if (bus_en) begin
      cap_q.push_back(bus_data);
      cap_cyc.push_back(cyc);
      cap_rdy.push_back(rdy_e);
    end else if (rst_e && bus_data !== prev_data) begin
      hold_bad++;
    end
    prev_data = bus_data;
  end

  function automatic logic [511:0] pay(input int n);
    return {16{32'(n) ^ 32'hC0DE0000}};
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_bus);
      #2;
    end
  endtask

  task automatic chk(input string tag, input logic [533:0] obs, input logic [533:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_caps();
    cap_q.delete();
    cap_cyc.delete();
    cap_rdy.delete();
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    bus_ready = 1'b0;
    tick(2);
    rst_n = 1'b1;
    clear_caps();
    tick(1);
  endtask

  task automatic push_words(input int base, input int n);
    int k     = 0;
    int guard = 0;
    while (k < n && guard < 1000) begin
      if (in_ready) begin
        in_valid = 1'b1;
        in_data  = pay(base + k);
        k++;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      guard++;
    end
    in_valid = 1'b0;
    chk($sformatf("push_done_%0d", base), 534'(k), 534'(n));
  endtask

  task automatic wait_caps(input int n, input int bound, input string tag);
    int g = 0;
    while (cap_q.size() < n && g < bound) begin
      tick();
      g++;
    end
    chk(tag, 534'(cap_q.size() >= n), 534'(1));
  endtask

  task automatic chk_word(input int qi, input int seq, input int idx, input logic [511:0] p);
    logic [533:0] d;
    d = (qi < cap_q.size()) ? cap_q[qi] : '0;
    chk($sformatf("w%0d_seq", qi),  534'(d[533:518]), 534'(seq));
    chk($sformatf("w%0d_idx", qi),  534'(d[517:513]), 534'(idx));
    chk($sformatf("w%0d_last", qi), 534'(d[512]),     534'(idx == 24));
    chk($sformatf("w%0d_pay", qi),  534'(d[511:0]),   534'(p));
  endtask

  initial begin
    int p_cyc;
    int bad;

    // Reset state
    tick(2);
    chk("rst_bus_en",   534'(bus_en),   534'(0));
    chk("rst_in_ready", 534'(in_ready), 534'(0));
    chk("rst_pkt_cnt",  534'(pkt_cnt),  534'(0));
    chk("rst_ovf",      534'(ovf_err),  534'(0));
    chk("rst_bus_data", bus_data,       534'(0));
    rst_n = 1'b1;
    tick(1);
    chk("in_ready_rise", 534'(in_ready), 534'(1));

    // 24 words wait; the 25th starts a packet of 25 consecutive words
    bus_ready = 1'b1;
    push_words(0, 24);
    tick(5);
    chk("no_start_24", 534'(cap_q.size()), 534'(0));
    push_words(24, 1);
    p_cyc = cyc;
    wait_caps(1, 10, "first_word_seen");
    chk("start_latency", 534'(cap_cyc.size() > 0 && (cap_cyc[0] - p_cyc) <= 2), 534'(1));
    wait_caps(25, 40, "pkt0_complete");
    tick(3);
    chk("pkt0_count", 534'(cap_q.size()), 534'(25));
    bad = 0;
    for (int i = 0; i < 25; i++) begin
      chk_word(i, 0, i, pay(i));
      if (i > 0 && i < cap_cyc.size() && cap_cyc[i] != cap_cyc[i-1] + 1) bad++;
    end
    chk("pkt0_back_to_back", 534'(bad), 534'(0));
    chk("pkt0_pkt_cnt", 534'(pkt_cnt), 534'(1));

    // 50 words: two packets with exactly two idle bus cycles between them
    do_reset();
    bus_ready = 1'b1;
    push_words(100, 50);
    wait_caps(50, 120, "two_pkts_complete");
    tick(3);
    chk("two_pkts_count", 534'(cap_q.size()), 534'(50));
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      chk_word(i, i / 25, i % 25, pay(100 + i));
      if (i > 0 && i != 25 && i < cap_cyc.size() && cap_cyc[i] != cap_cyc[i-1] + 1) bad++;
    end
    chk("two_pkts_back_to_back", 534'(bad), 534'(0));
    chk("idle_between_pkts", 534'(cap_cyc.size() == 50 ? cap_cyc[25] - cap_cyc[24] - 1 : -1), 534'(2));
    chk("two_pkts_pkt_cnt", 534'(pkt_cnt), 534'(2));

    // bus_ready toggling every cycle mid-packet
    do_reset();
    push_words(200, 25);
    tick(3);
    chk("stall_no_issue", 534'(cap_q.size()), 534'(0));
    for (int i = 0; i < 80; i++) begin
      bus_ready = ~bus_ready;
      tick();
    end
    bus_ready = 1'b0;
    wait_caps(25, 10, "toggle_complete");
    chk("toggle_count", 534'(cap_q.size()), 534'(25));
    bad = 0;
    for (int i = 0; i < cap_rdy.size(); i++) if (!cap_rdy[i]) bad++;
    chk("toggle_en_only_when_ready", 534'(bad), 534'(0));
    for (int i = 0; i < 25; i++) chk_word(i, 0, i, pay(200 + i));
    chk("toggle_hold_data", 534'(hold_bad), 534'(0));

    // Pops blocked: in_ready falls at 29, overflow on the 33rd word
    do_reset();
    bus_ready = 1'b0;
    for (int k = 0; k < 33; k++) begin
      in_valid = 1'b1;
      in_data  = pay(300 + k);
      tick();
      if (k == 27) chk("in_ready_at_28", 534'(in_ready), 534'(1));
      if (k == 28) chk("in_ready_at_29", 534'(in_ready), 534'(0));
      if (k == 31) chk("ovf_at_32",      534'(ovf_err),  534'(0));
      if (k == 32) chk("ovf_at_33",      534'(ovf_err),  534'(1));
    end
    in_valid = 1'b0;
    tick(3);
    chk("ovf_sticky", 534'(ovf_err), 534'(1));
    bus_ready = 1'b1;
    wait_caps(25, 40, "ovf_pkt0_complete");
    tick(6);
    chk("ovf_partial_held", 534'(cap_q.size()), 534'(25));
    push_words(400, 18);
    wait_caps(50, 80, "ovf_pkt1_complete");
    tick(3);
    chk("ovf_total_count", 534'(cap_q.size()), 534'(50));
    for (int i = 0; i < 25; i++) chk_word(i, 0, i, pay(300 + i));
    for (int j = 0; j < 25; j++) chk_word(25 + j, 1, j, (j < 7) ? pay(325 + j) : pay(400 + j - 7));
    chk("ovf_still_set", 534'(ovf_err), 534'(1));
    chk("ovf_pkt_cnt", 534'(pkt_cnt), 534'(2));

    // Reset at word_idx 10
    do_reset();
    bus_ready = 1'b1;
    push_words(500, 25);
    wait_caps(11, 40, "mid_pkt_reached");
    rst_n = 1'b0;
    tick(1);
    chk("midrst_bus_en",   534'(bus_en),   534'(0));
    chk("midrst_bus_data", bus_data,       534'(0));
    chk("midrst_in_ready", 534'(in_ready), 534'(0));
    chk("midrst_pkt_cnt",  534'(pkt_cnt),  534'(0));
    chk("midrst_ovf",      534'(ovf_err),  534'(0));
    rst_n = 1'b1;
    clear_caps();
    tick(10);
    chk("midrst_discarded", 534'(cap_q.size()), 534'(0));
    push_words(600, 25);
    wait_caps(25, 40, "post_rst_pkt_complete");
    tick(3);
    chk("post_rst_count", 534'(cap_q.size()), 534'(25));
    chk_word(0, 0, 0, pay(600));
    chk_word(24, 0, 24, pay(624));
    chk("post_rst_pkt_cnt", 534'(pkt_cnt), 534'(1));
    chk("final_hold_data", 534'(hold_bad), 534'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
